decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I/RV32E instruction decode stage. It sits between fetch and execute. It fully decodes all RV32I base opcodes and flags illegal encodings. Results are buffered in a DEPTH-entry output queue using valid/ready handshakes, and the queue can be flushed when the pipeline redirects.

Parameters:
DEPTH, 2, output queue entries (1..8)
NUM_REGS, 32, architectural register count (32 = RV32I, 16 = RV32E)
RA_W, $clog2(NUM_REGS), register address width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  discard all queued entries and any input accepted this cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept an instruction
in_instr  in  32  raw instruction, rv32i_inst_u
in_pc  in  32  instruction address
out_valid  out  1  queue head valid
out_ready  in  1  execute consumes head
out_pc  out  32  head pc
out_rs1 / out_rs2 / out_rd  out  RA_W each  register indices
out_imm  out  32  sign-extended immediate
out_optype  out  optype_e  R/I/S/B/U/J
out_alu_op  out  alu_op_e  ALU operation
out_r_we  out  1  register write enable
out_m_we  out  1  memory write (stores)
out_m_re  out  1  memory read (loads)
out_illegal  out  1  illegal instruction

Behaviour:
- Reset (rst_n low, asynchronous): queue empty; out_valid=0; all out_* fields 0; in_ready=1 after release.
- Decode is combinational from in_instr and is captured into the queue on in_valid && in_ready. Latency is 1 cycle: the earliest out_valid is the cycle after acceptance.
- in_ready = (count < DEPTH). There is no same-cycle pass-through when full.
- Pop occurs on out_valid && out_ready. Simultaneous push and pop leaves count unchanged. Read/write pointers wrap modulo DEPTH.
- FIFO order is strict. Head fields are stable while out_valid && !out_ready.
- flush: the next state is empty with pointers reset. A push in the same cycle is dropped and a pop is ignored. in_ready is unaffected during flush.
- optype is derived from opcode:
  - LUI/AUIPC → U
  - JAL → J
  - JALR/LOAD/OP-IMM/FENCE/SYSTEM → I
  - STORE → S
  - BRANCH → B
  - OP → R
- Immediates:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - U: {instr[31:12], 12'b0}
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - R: 0
- Unused fields are 0. rs2 is 0 for I/U/J; rd is 0 for S/B.
- alu_op:
  - OP/OP-IMM map via funct3/funct7[5] to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - BRANCH funct3 maps to BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LUI/AUIPC/LOAD/STORE/JAL/JALR → ADD.
- r_we = 1 for U/J/I/R types except FENCE, SYSTEM and illegal, and is forced to 0 when rd==0.
- m_we = 1 for STORE only. m_re = 1 for LOAD only.
- Illegal is raised by any of:
  - instr[1:0] != 2'b11
  - unknown opcode
  - LOAD funct3 ∉ {0,1,2,4,5}
  - STORE funct3 > 2
  - BRANCH funct3 ∈ {2,3}
  - JALR funct3 != 0
  - OP funct7 ∉ {0x00,0x20}
  - OP funct7=0x20 with funct3 ∉ {0,5}
  - OP-IMM shifts with bad funct7
  - any used register index ≥ NUM_REGS
- On illegal: out_illegal=1; r_we/m_we/m_re=0; imm=0; alu_op=ADD; pc is still carried. Illegal entries occupy a queue slot like any other.

Test Plan:
- Reset: hold rst_n=0 mid-stream with 2 entries queued → out_valid=0 immediately (asynchronous); after release in_ready=1 and the queue is empty.
- Decode table:
  - 0x123452B7 (lui x5) → rd=5, imm=0x12345000, UTYPE, ADD, r_we=1.
  - 0xFFF00093 (addi x1,x0,-1) → imm=0xFFFFFFFF.
  - 0x0020A423 (sw x2,8(x1)) → rs1=1, rs2=2, imm=8, m_we=1, r_we=0.
  - 0xFE208EE3 (beq x1,x2,-4) → imm=0xFFFFFFFC, BEQ, r_we=0.
- Illegal: 0x00000000 → out_illegal=1, r_we=0.
- RV32E: with NUM_REGS=16, 0x000800B3 (add x1,x16,x0) → out_illegal=1. With NUM_REGS=32 the same word is legal with rs1=16.
- Backpressure, DEPTH=2: push 3 instructions with out_ready=0 → in_ready=0 after 2 pushes. Then assert out_ready → the 3 pcs emerge in order and no entry is lost or duplicated.
- Flush: queue holds 2 entries, and in the same cycle in_valid=1 and flush=1 → next cycle out_valid=0. The dropped instruction never appears, and a subsequent push appears 1 cycle later.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: combinational decode of the fetched word, buffered
// in a small valid/ready output queue that can be flushed on a pipeline redirect.

package decode_stage_pkg;

    typedef enum logic [2:0] {
        OPT_R = 3'd0,
        OPT_I = 3'd1,
        OPT_S = 3'd2,
        OPT_B = 3'd3,
        OPT_U = 3'd4,
        OPT_J = 3'd5
    } optype_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv32i_fields_t;

    typedef union packed {
        logic [31:0]   raw;
        rv32i_fields_t f;
    } rv32i_inst_u;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int NUM_REGS = 32,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  rv32i_inst_u     in_instr,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [RA_W-1:0] out_rs1,
    output logic [RA_W-1:0] out_rs2,
    output logic [RA_W-1:0] out_rd,
    output logic [31:0]     out_imm,
    output optype_e         out_optype,
    output alu_op_e         out_alu_op,
    output logic            out_r_we,
    output logic            out_m_we,
    output logic            out_m_re,
    output logic            out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [31:0]     imm;
        optype_e         optype;
        alu_op_e         alu_op;
        logic            r_we;
        logic            m_we;
        logic            m_re;
        logic            illegal;
    } entry_t;

    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e branch_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_BEQ;
            3'd1:    return ALU_BNE;
            3'd4:    return ALU_BLT;
            3'd5:    return ALU_BGE;
            3'd6:    return ALU_BLTU;
            3'd7:    return ALU_BGEU;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic reg_oob(input logic [4:0] idx);
        return int'(idx) >= NUM_REGS;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        use_rs1, use_rs2, use_rd, no_wb, bad;
    entry_t      dec;

    assign opcode = in_instr.f.opcode;
    assign funct3 = in_instr.f.funct3;
    assign funct7 = in_instr.f.funct7;
    assign rs1_f  = in_instr.f.rs1;
    assign rs2_f  = in_instr.f.rs2;
    assign rd_f   = in_instr.f.rd;

    assign imm_i = {{20{in_instr.raw[31]}}, in_instr.raw[31:20]};
    assign imm_s = {{20{in_instr.raw[31]}}, in_instr.raw[31:25], in_instr.raw[11:7]};
    assign imm_b = {{19{in_instr.raw[31]}}, in_instr.raw[31], in_instr.raw[7],
                    in_instr.raw[30:25], in_instr.raw[11:8], 1'b0};
    assign imm_u = {in_instr.raw[31:12], 12'h000};
    assign imm_j = {{11{in_instr.raw[31]}}, in_instr.raw[31], in_instr.raw[19:12],
                    in_instr.raw[20], in_instr.raw[30:21], 1'b0};

    // Illegal words still take a queue slot, but with every side effect cleared.
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        no_wb   = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.optype = OPT_U; dec.imm = imm_u; use_rd = 1'b1;
            end
            OPC_JAL: begin
                dec.optype = OPT_J; dec.imm = imm_j; use_rd = 1'b1;
            end
            OPC_JALR: begin
                dec.optype = OPT_I; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
                bad = (funct3 != 3'd0);
            end
            OPC_LOAD: begin
                dec.optype = OPT_I; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
                dec.m_re = 1'b1;
                bad = !(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            OPC_STORE: begin
                dec.optype = OPT_S; dec.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.m_we = 1'b1;
                bad = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                dec.optype = OPT_B; dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.alu_op = branch_op(funct3);
                bad = (funct3 inside {3'd2, 3'd3});
            end
            OPC_OPIMM: begin
                dec.optype = OPT_I; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
                dec.alu_op = arith_op(funct3, (funct3 == 3'd5) && funct7[5]);
                bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                      ((funct3 == 3'd5) && !(funct7 inside {7'h00, 7'h20}));
            end
            OPC_OP: begin
                dec.optype = OPT_R; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                dec.alu_op = arith_op(funct3, funct7[5]);
                bad = !(funct7 inside {7'h00, 7'h20}) ||
                      ((funct7 == 7'h20) && !(funct3 inside {3'd0, 3'd5}));
            end
            OPC_FENCE, OPC_SYSTEM: begin
                dec.optype = OPT_I; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
                no_wb = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        bad = bad || (in_instr.raw[1:0] != 2'b11) ||
              (use_rs1 && reg_oob(rs1_f)) || (use_rs2 && reg_oob(rs2_f)) ||
              (use_rd && reg_oob(rd_f));
        dec.rs1  = use_rs1 ? rs1_f[RA_W-1:0] : '0;
        dec.rs2  = use_rs2 ? rs2_f[RA_W-1:0] : '0;
        dec.rd   = use_rd  ? rd_f[RA_W-1:0]  : '0;
        dec.r_we = use_rd && !no_wb && (rd_f != 5'd0);
        if (bad) begin
            dec.illegal = 1'b1;
            dec.imm     = '0;
            dec.alu_op  = ALU_ADD;
            dec.r_we    = 1'b0;
            dec.m_we    = 1'b0;
            dec.m_re    = 1'b0;
        end
    end

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head        = out_valid ? mem[rd_ptr] : '0;
    assign out_pc      = head.pc;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_imm     = head.imm;
    assign out_optype  = head.optype;
    assign out_alu_op  = head.alu_op;
    assign out_r_we    = head.r_we;
    assign out_m_we    = head.m_we;
    assign out_m_re    = head.m_re;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32I and an RV32E instance share one
// stimulus stream; expected entries come from a behavioural decoder model.

module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        in_ready, out_valid, out_r_we, out_m_we, out_m_re, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    optype_e     out_optype;
    alu_op_e     out_alu_op;

    logic        e_in_ready, e_out_valid, e_out_r_we, e_out_m_we, e_out_m_re, e_out_illegal;
    logic [31:0] e_out_pc, e_out_imm;
    logic [3:0]  e_out_rs1, e_out_rs2, e_out_rd;
    optype_e     e_out_optype;
    alu_op_e     e_out_alu_op;

    always #5 clk = ~clk;

    decode_stage #(.DEPTH(DEPTH), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_optype(out_optype), .out_alu_op(out_alu_op), .out_r_we(out_r_we),
        .out_m_we(out_m_we), .out_m_re(out_m_re), .out_illegal(out_illegal)
    );

    decode_stage #(.DEPTH(DEPTH), .NUM_REGS(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
        .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd), .out_imm(e_out_imm),
        .out_optype(e_out_optype), .out_alu_op(e_out_alu_op), .out_r_we(e_out_r_we),
        .out_m_we(e_out_m_we), .out_m_re(e_out_m_re), .out_illegal(e_out_illegal)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        optype_e     optype;
        alu_op_e     alu_op;
        logic        r_we;
        logic        m_we;
        logic        m_re;
        logic        illegal;
        longint      avail;
    } exp_t;

    exp_t   q32[$];
    exp_t   q16[$];
    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;
    logic   acc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t refDecode(logic [31:0] w, logic [31:0] pc, int nregs);
        exp_t       e;
        alu_op_e    arith [8];
        alu_op_e    branch [8];
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok, urs1, urs2, urd, wb;
        arith  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        branch = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        f3 = w[14:12];
        f7 = w[31:25];
        e.pc = pc; e.rs1 = 0; e.rs2 = 0; e.rd = 0; e.imm = 0;
        e.optype = OPT_R; e.alu_op = ALU_ADD;
        e.r_we = 0; e.m_we = 0; e.m_re = 0; e.illegal = 0; e.avail = 0;
        ok = 1; urs1 = 0; urs2 = 0; urd = 0; wb = 0;
        case (w[6:0])
            7'h37, 7'h17: begin
                e.optype = OPT_U; e.imm = {w[31:12], 12'h000}; urd = 1; wb = 1;
            end
            7'h6F: begin
                e.optype = OPT_J;
                e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                urd = 1; wb = 1;
            end
            7'h67: begin
                e.optype = OPT_I; e.imm = {{20{w[31]}}, w[31:20]};
                urs1 = 1; urd = 1; wb = 1; ok = (f3 == 0);
            end
            7'h03: begin
                e.optype = OPT_I; e.imm = {{20{w[31]}}, w[31:20]};
                urs1 = 1; urd = 1; wb = 1; e.m_re = 1;
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            end
            7'h23: begin
                e.optype = OPT_S; e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                urs1 = 1; urs2 = 1; e.m_we = 1; ok = (f3 <= 2);
            end
            7'h63: begin
                e.optype = OPT_B;
                e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                urs1 = 1; urs2 = 1; e.alu_op = branch[f3];
                ok = !(f3 inside {3'd2, 3'd3});
            end
            7'h13: begin
                e.optype = OPT_I; e.imm = {{20{w[31]}}, w[31:20]};
                urs1 = 1; urd = 1; wb = 1; e.alu_op = arith[f3];
                if (f3 == 5 && f7 == 7'h20) e.alu_op = ALU_SRA;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = f7 inside {7'h00, 7'h20};
            end
            7'h33: begin
                e.optype = OPT_R; urs1 = 1; urs2 = 1; urd = 1; wb = 1;
                e.alu_op = arith[f3];
                if (f7 == 7'h20) begin
                    if (f3 == 0) e.alu_op = ALU_SUB;
                    else if (f3 == 5) e.alu_op = ALU_SRA;
                    else ok = 0;
                end else if (f7 != 0) ok = 0;
            end
            7'h0F, 7'h73: begin
                e.optype = OPT_I; e.imm = {{20{w[31]}}, w[31:20]};
                urs1 = 1; urd = 1;
            end
            default: ok = 0;
        endcase
        if (w[1:0] != 2'b11) ok = 0;
        if (urs1 && int'(w[19:15]) >= nregs) ok = 0;
        if (urs2 && int'(w[24:20]) >= nregs) ok = 0;
        if (urd && int'(w[11:7]) >= nregs) ok = 0;
        e.rs1  = urs1 ? w[19:15] : 5'd0;
        e.rs2  = urs2 ? w[24:20] : 5'd0;
        e.rd   = urd  ? w[11:7]  : 5'd0;
        e.r_we = wb && (w[11:7] != 0);
        if (!ok) begin
            e.illegal = 1; e.imm = 0; e.alu_op = ALU_ADD;
            e.r_we = 0; e.m_we = 0; e.m_re = 0;
        end
        return e;
    endfunction

    function automatic exp_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic [31:0] imm, optype_e ot, alu_op_e ao,
                                logic rwe, logic mwe, logic mre, logic ill);
        exp_t e;
        e.pc = 0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.optype = ot; e.alu_op = ao; e.r_we = rwe; e.m_we = mwe; e.m_re = mre;
        e.illegal = ill; e.avail = 0;
        return e;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            w[24] = 1'b0; w[19] = 1'b0; w[11] = 1'b0;
        end
        if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom);
        return w;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compareHead(string tag, exp_t e, logic [31:0] pc, logic [4:0] rs1,
                               logic [4:0] rs2, logic [4:0] rd, logic [31:0] imm,
                               optype_e ot, alu_op_e ao, logic rwe, logic mwe,
                               logic mre, logic ill);
        checkOutput({tag, ".pc"}, pc, e.pc);
        checkOutput({tag, ".illegal"}, 32'(ill), 32'(e.illegal));
        checkOutput({tag, ".r_we"}, 32'(rwe), 32'(e.r_we));
        checkOutput({tag, ".m_we"}, 32'(mwe), 32'(e.m_we));
        checkOutput({tag, ".m_re"}, 32'(mre), 32'(e.m_re));
        checkOutput({tag, ".imm"}, imm, e.imm);
        checkOutput({tag, ".alu_op"}, 32'(ao), 32'(e.alu_op));
        if (!e.illegal) begin
            checkOutput({tag, ".rs1"}, 32'(rs1), 32'(e.rs1));
            checkOutput({tag, ".rs2"}, 32'(rs2), 32'(e.rs2));
            checkOutput({tag, ".rd"}, 32'(rd), 32'(e.rd));
            checkOutput({tag, ".optype"}, 32'(ot), 32'(e.optype));
        end
    endtask

    // Monitor: compares each presented head against the scoreboard, then retires it.
    initial begin
        bit v32, v16;
        forever begin
            @(negedge clk);
            v32 = 0;
            v16 = 0;
            if (q32.size() > 0) v32 = (q32[0].avail <= cyc);
            if (q16.size() > 0) v16 = (q16[0].avail <= cyc);
            checkOutput("out_valid", 32'(out_valid), 32'(v32));
            checkOutput("e.out_valid", 32'(e_out_valid), 32'(v16));
            if (out_valid && v32)
                compareHead("rv32i", q32[0], out_pc, out_rs1, out_rs2, out_rd, out_imm,
                            out_optype, out_alu_op, out_r_we, out_m_we, out_m_re, out_illegal);
            if (e_out_valid && v16)
                compareHead("rv32e", q16[0], e_out_pc, {1'b0, e_out_rs1}, {1'b0, e_out_rs2},
                            {1'b0, e_out_rd}, e_out_imm, e_out_optype, e_out_alu_op,
                            e_out_r_we, e_out_m_we, e_out_m_re, e_out_illegal);
            if (flush) begin
                q32.delete();
                q16.delete();
            end else begin
                if (out_valid && out_ready && v32) void'(q32.pop_front());
                if (e_out_valid && out_ready && v16) void'(q16.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                                 input logic fl, input logic ordy, output logic accepted);
        exp_t e32, e16;
        @(posedge clk);
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(q32.size() < DEPTH));
        checkOutput("e.in_ready", 32'(e_in_ready), 32'(q16.size() < DEPTH));
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        accepted  = v && in_ready && !fl;
        if (accepted) begin
            e32 = refDecode(w, pc, 32);
            e16 = refDecode(w, pc, 16);
            e32.avail = cyc + 1;
            e16.avail = cyc + 1;
            q32.push_back(e32);
            q16.push_back(e16);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic ordy);
        bit done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            applyStimulus(1'b1, w, pc, 1'b0, ordy, acc);
            done = acc;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_timeout: pc 0x%08h never accepted", pc);
        end
    endtask

    task automatic sendDirected(input logic [31:0] w, input logic [31:0] pc, input exp_t e32,
                                input bit ovr16, input exp_t e16);
        send(w, pc, 1'b1);
        if (q32.size() > 0) begin
            e32.pc = pc;
            e32.avail = q32[q32.size()-1].avail;
            q32[q32.size()-1] = e32;
        end
        if (ovr16 && q16.size() > 0) begin
            e16.pc = pc;
            e16.avail = q16[q16.size()-1].avail;
            q16[q16.size()-1] = e16;
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, ordy, acc);
    endtask

    task automatic drain();
        int t = 0;
        while ((q32.size() > 0 || q16.size() > 0) && t < 30) begin
            idle(1, 1'b1);
            t++;
        end
        n_checks++;
        if (q32.size() > 0 || q16.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d/%0d entries still expected, required 0", q32.size(), q16.size());
        end
    endtask

    initial begin
        exp_t none;
        logic [31:0] pc;
        none = mk(0, 0, 0, 0, OPT_R, ALU_ADD, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1, 1'b1);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed decode table");
        sendDirected(32'h123452B7, 32'h100, mk(0, 0, 5, 32'h12345000, OPT_U, ALU_ADD, 1, 0, 0, 0), 0, none);
        sendDirected(32'hFFF00093, 32'h104, mk(0, 0, 1, 32'hFFFFFFFF, OPT_I, ALU_ADD, 1, 0, 0, 0), 0, none);
        sendDirected(32'h0020A423, 32'h108, mk(1, 2, 0, 32'h8, OPT_S, ALU_ADD, 0, 1, 0, 0), 0, none);
        sendDirected(32'hFE208EE3, 32'h10C, mk(1, 2, 0, 32'hFFFFFFFC, OPT_B, ALU_BEQ, 0, 0, 0, 0), 0, none);
        sendDirected(32'h00000000, 32'h110, mk(0, 0, 0, 0, OPT_R, ALU_ADD, 0, 0, 0, 1), 0, none);
        sendDirected(32'h000800B3, 32'h114, mk(16, 0, 1, 0, OPT_R, ALU_ADD, 1, 0, 0, 0),
                     1, mk(0, 0, 0, 0, OPT_R, ALU_ADD, 0, 0, 0, 1));
        drain();

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0, acc);
        checkOutput("bp.in_ready_full", 32'(in_ready), 32'd0);
        send(32'h00300213, 32'h208, 1'b1);
        drain();

        $display("[TB] flush");
        send(32'h00100113, 32'h300, 1'b0);
        send(32'h00200193, 32'h304, 1'b0);
        applyStimulus(1'b1, 32'h00300213, 32'h308, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
        send(32'h00400293, 32'h30C, 1'b1);
        send(32'h00500313, 32'h400, 1'b0);
        applyStimulus(1'b1, 32'h00600393, 32'h404, 1'b1, 1'b0, acc);
        drain();

        $display("[TB] mid-stream reset");
        send(32'h00100113, 32'h500, 1'b0);
        send(32'h00200193, 32'h504, 1'b0);
        idle(1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q32.delete();
        q16.delete();
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.e.out_valid", 32'(e_out_valid), 32'd0);
        checkOutput("rst.out_pc", out_pc, 32'd0);
        checkOutput("rst.out_rd", 32'(out_rd), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(1, 1'b1);
        checkOutput("rst_release.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_release.out_valid", 32'(out_valid), 32'd0);

        $display("[TB] randomized traffic");
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randInstr(), pc,
                          $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, acc);
            pc += 4;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
